// File: rtl/pt_dec.sv
// PT2262-style pulse-width decoder: synchronizes the serial line, classifies
// high pulses as short/long, decodes 12 trits per frame and reports a code once two identical frames are seen.
module pt_dec #(
    parameter int SHORT_MAX = 7,
    parameter int LONG_MAX  = 15,
    parameter int GAP_MIN   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d,
    output logic [23:0] ad,
    output logic        vld,
    output logic        err
);

    localparam logic [7:0] SHORT_CNT = 8'(SHORT_MAX);
    localparam logic [7:0] LONG_CNT  = 8'(LONG_MAX);
    localparam logic [7:0] LOW_TO    = 8'(LONG_MAX + 1);
    localparam logic [7:0] GAP_CNT   = 8'(GAP_MIN);

    typedef enum logic [1:0] {HUNT, ARMED, DATA, SYNC} state_t;
    typedef enum logic [1:0] {CLS_S, CLS_L, CLS_BAD} cls_t;

    state_t      state, state_nxt;
    cls_t        cls;
    logic        d_m, d_s, d_q;
    logic        rise, fall;
    logic [7:0]  hcnt, lcnt;
    logic [4:0]  hidx;
    logic [23:0] hb;
    logic        sync_seen;
    logic [23:0] prev;
    logic        prev_ok;
    logic [23:0] code;
    logic        pair_bad;
    logic        go_data, store, sync_hit, abort, done;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_m <= 1'b0;
            d_s <= 1'b0;
            d_q <= 1'b0;
        end else begin
            d_m <= d;
            d_s <= d_m;
            d_q <= d_s;
        end
    end

    assign rise = d_s & ~d_q;
    assign fall = ~d_s & d_q;

    // Each counter runs while d_s sits at its level and is cleared by the opposite level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= 8'd0;
            lcnt <= 8'd0;
        end else if (d_s) begin
            hcnt <= (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
            lcnt <= 8'd0;
        end else begin
            lcnt <= (lcnt == 8'hFF) ? lcnt : lcnt + 8'd1;
            hcnt <= 8'd0;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        cls = CLS_BAD;
        if (hcnt >= 8'd2 && hcnt <= SHORT_CNT)
            cls = CLS_S;
        else if (hcnt > SHORT_CNT && hcnt <= LONG_CNT)
            cls = CLS_L;
    end

    // Half-bit pair (first, second) with L=1: SS->00, LL->01, SL->10, LS invalid.
    always_comb begin
        code     = 24'd0;
        pair_bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            code[23-2*i -: 2] = {~hb[2*i] & hb[2*i+1], hb[2*i] & hb[2*i+1]};
            if (hb[2*i] && !hb[2*i+1])
                pair_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HUNT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go_data   = 1'b0;
        store     = 1'b0;
        sync_hit  = 1'b0;
        abort     = 1'b0;
        done      = 1'b0;
        unique case (state)
            HUNT: begin
                if (lcnt == GAP_CNT)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    go_data   = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    if (cls == CLS_BAD) begin
                        abort = 1'b1;
                    end else begin
                        store = 1'b1;
                        if (hidx == 5'd23)
                            state_nxt = SYNC;
                    end
                end else if (lcnt == LOW_TO) begin
                    abort = 1'b1;
                end
            end
            SYNC: begin
                if (!sync_seen) begin
                    if (fall) begin
                        if (cls == CLS_S) sync_hit = 1'b1;
                        else              abort    = 1'b1;
                    end else if (lcnt == LOW_TO) begin
                        abort = 1'b1;
                    end
                end else if (rise) begin
                    abort = 1'b1;
                end else if (lcnt == GAP_CNT) begin
                    // The sync gap also serves as the lead-in of the next frame.
                    done      = 1'b1;
                    state_nxt = ARMED;
                end
            end
            default: state_nxt = HUNT;
        endcase
        if (abort)
            state_nxt = HUNT;
    end

    // NOTE: the frame storage is reset too, so a stale frame can never match after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hidx      <= 5'd0;
            hb        <= 24'd0;
            sync_seen <= 1'b0;
            prev      <= 24'd0;
            prev_ok   <= 1'b0;
            ad        <= 24'd0;
            vld       <= 1'b0;
            err       <= 1'b0;
        end else begin
            vld <= 1'b0;
            err <= 1'b0;
            if (go_data) begin
                hidx      <= 5'd0;
                sync_seen <= 1'b0;
            end
            if (store) begin
                hb[hidx] <= (cls == CLS_L);
                hidx     <= hidx + 5'd1;
            end
            if (sync_hit)
                sync_seen <= 1'b1;
            if (abort) begin
                err     <= 1'b1;
                prev_ok <= 1'b0;
            end
            if (done) begin
                if (pair_bad) begin
                    err     <= 1'b1;
                    prev_ok <= 1'b0;
                end else begin
                    if (prev_ok && code == prev) begin
                        ad  <= code;
                        vld <= 1'b1;
                    end
                    prev    <= code;
                    prev_ok <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pt_dec.md
PT_DEC -- requirements
Module: pt_dec

Interface
Parameters:
REQ-001 SHALL have parameter SHORT_MAX, default 7: longest high time, in clk cycles, classified as a short pulse.
REQ-002 SHALL have parameter LONG_MAX, default 15: longest high time, in clk cycles, classified as a long pulse.
REQ-003 SHALL have parameter GAP_MIN, default 64: low time, in clk cycles, that identifies a sync gap.

Ports:
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port d, input, 1: asynchronous serial PT2262-format line from the encoder.
REQ-007 SHALL have port ad, output, 24: last accepted code word, 2 bits per trit, first received trit in ad[23:22].
REQ-008 SHALL have port vld, output, 1: one-cycle pulse when ad is updated.
REQ-009 SHALL have port err, output, 1: one-cycle pulse when a frame is aborted.

Function
REQ-010 SHALL pass d through a 2-flop synchronizer (d_s); all timing is measured on d_s.
REQ-011 SHALL count high time (hcnt) and low time (lcnt) of d_s in 8-bit counters that saturate at 255 and clear on the opposite edge.
REQ-012 SHALL classify each high pulse at its falling edge: 2..SHORT_MAX = S; SHORT_MAX+1..LONG_MAX = L; anything else = BAD.
REQ-013 SHALL decode trits from half-bit pairs: (S,S)=2'b00, (L,L)=2'b01, (S,L)=2'b10; (L,S) is invalid.
REQ-014 SHALL implement states HUNT, ARMED, DATA and SYNC.
REQ-015 HUNT: on lcnt reaching GAP_MIN, go to ARMED.
REQ-016 ARMED: on the next rising edge of d_s, go to DATA with the half-bit index set to 0.
REQ-017 DATA: each falling edge stores the class of that high pulse at the half-bit index and increments the index.
REQ-018 DATA: after the 24th half-bit, go to SYNC.
REQ-019 DATA: a BAD pulse, or lcnt reaching LONG_MAX+1 before the 24th half-bit, SHALL pulse err and go to HUNT.
REQ-020 SYNC: the high pulse after half-bit 24 SHALL classify as S; otherwise pulse err and go to HUNT.
REQ-021 SYNC: once lcnt then reaches GAP_MIN, the frame is complete; go to ARMED, because the sync gap is shared with the next frame.
REQ-022 On frame completion, any (L,S) pair SHALL pulse err, clear prev_ok, and discard the frame.
REQ-023 On frame completion, a frame equal to the stored previous frame with prev_ok=1 SHALL load ad and pulse vld in the cycle after lcnt reaches GAP_MIN.
REQ-024 On frame completion, every valid frame SHALL be stored as the previous frame and set prev_ok.
REQ-025 Each further identical frame SHALL pulse vld again, with ad unchanged in value.
REQ-026 A differing valid frame SHALL replace the stored frame without pulsing vld.
REQ-027 err SHALL clear prev_ok.
REQ-028 ad SHALL hold its value between vld pulses.
REQ-029 vld and err SHALL never be high in the same cycle.
REQ-030 Saturated lcnt in HUNT or ARMED SHALL NOT generate err.
REQ-031 d held high indefinitely SHALL yield BAD at its eventual fall: err if in DATA or SYNC, ignored otherwise.

Reset
REQ-032 While rst=0, the state SHALL be HUNT.
REQ-033 While rst=0, ad=24'h000000, vld=0, err=0.
REQ-034 While rst=0, counters, half-bit index, stored frame, prev_ok and both synchronizer flops SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame with no vld or err pulse.
REQ-036 Decoding after reset release SHALL require a fresh sync gap.

Verification
REQ-037 Two identical frames with ad=24'b000100000001010101001010 (S=4 high/12 low, L=12 high/4 low, sync 4 high/124 low) -> no vld after the first frame; one vld after the second sync gap with ad equal to that value; err never asserted.
REQ-038 Three identical frames -> vld pulses after the 2nd and 3rd frames; ad stable throughout.
REQ-039 Frame A then a frame differing in trit 0 -> no vld; a third frame equal to the second -> vld with the second frame's code.
REQ-040 Trit sent as (L,S) -> err pulse at the sync gap, no vld; the next two good frames -> vld only after the second of them.
REQ-041 A 20-cycle high pulse at half-bit 5 -> err at its falling edge, state HUNT; a subsequent pair of good frames decodes correctly.
REQ-042 rst=0 during half-bit 10 of a second identical frame -> outputs zero immediately, no vld; after release, two full frames are needed before vld.
